// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the SRAM arbiter/sequencer.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_TA   = 2'd3
  } state_t;

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone request wins outright, a tie goes to
// the requester named by the pointer, and each transfer hands priority over.
module rr_arb2
  import sram_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       enable,
  input  logic       advance,
  output logic [1:0] gnt,
  output logic       ptr
);

  // One-hot winner selection, suppressed while the sequencer is busy
  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      if (req == 2'b11) begin
        gnt = (ptr == ID_B) ? 2'b10 : 2'b01;
      end else begin
        gnt = req;
      end
    end
  end

  // Priority pointer moves to the requester that just lost the turn
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= ID_A;
    end else if (advance && (gnt != 2'b00)) begin
      ptr <= gnt[ID_A] ? ID_B : ID_A;
    end
  end

endmodule

// File: rtl/sram_arb_ctrl.sv
// Round-robin arbiter and sequencer in front of a single-port synchronous
// SRAM. Runs one command at a time, owns the tristate data bus and inserts
// a turnaround cycle after every read before the bus can be driven again.
module sram_arb_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_rvalid,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rvalid,
  output logic              sram_cs,
  output logic              sram_we,
  output logic              sram_oe,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_data
);

  localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              arb_ptr;
  logic              xfer;
  logic              win_id;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              cmd_id;
  logic [2:0]        lat_cnt;
  logic              rd_last;
  logic              bus_drv;

  assign req     = {b_req, a_req};
  assign xfer    = |(req & gnt);
  assign win_id  = (a_req && b_req) ? arb_ptr : b_req;
  assign rd_last = (state == ST_RD) && (lat_cnt == 3'd0);
  assign a_gnt   = gnt[ID_A];
  assign b_gnt   = gnt[ID_B];

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .enable  (state == ST_IDLE),
    .advance (xfer),
    .gnt     (gnt),
    .ptr     (arb_ptr)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and SRAM pin / rvalid decode
  always_comb begin
    state_nxt = state;
    sram_cs   = 1'b0;
    sram_we   = 1'b0;
    sram_oe   = 1'b0;
    sram_addr = '0;
    bus_drv   = 1'b0;
    a_rvalid  = 1'b0;
    b_rvalid  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (xfer) begin
          state_nxt = (win_id == ID_B ? b_we : a_we) ? ST_WR : ST_RD;
        end
      end
      ST_WR: begin
        sram_cs   = 1'b1;
        sram_we   = 1'b1;
        sram_addr = cmd_addr;
        bus_drv   = 1'b1;
        state_nxt = ST_IDLE;
      end
      ST_RD: begin
        sram_cs   = 1'b1;
        sram_oe   = 1'b1;
        sram_addr = cmd_addr;
        if (lat_cnt == 3'd0) begin
          state_nxt = ST_TA;
        end
      end
      ST_TA: begin
        a_rvalid  = (cmd_id == ID_A);
        b_rvalid  = (cmd_id == ID_B);
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Command latch, captured on the accepted transfer only
  always_ff @(posedge clk) begin
    if (xfer) begin
      cmd_id    <= win_id;
      cmd_we    <= (win_id == ID_B) ? b_we    : a_we;
      cmd_addr  <= (win_id == ID_B) ? b_addr  : a_addr;
      cmd_wdata <= (win_id == ID_B) ? b_wdata : a_wdata;
    end
  end

  // Read-latency down-counter; zero marks the last cycle of ST_RD
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_cnt <= 3'd0;
    end else if (xfer) begin
      lat_cnt <= LAT_LOAD;
    end else if ((state == ST_RD) && (lat_cnt != 3'd0)) begin
      lat_cnt <= lat_cnt - 3'd1;
    end
  end

  // Read data capture into the issuing requester's holding register
  always_ff @(posedge clk) begin
    if (rst) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else if (rd_last) begin
      if (cmd_id == ID_A) begin
        a_rdata <= sram_data;
      end else begin
        b_rdata <= sram_data;
      end
    end
  end

  assign sram_data = bus_drv ? cmd_wdata : {DATA_W{1'bz}};

  // cmd_we is kept for visibility of the accepted command; the FSM branches
  // on the live request at the transfer edge instead.
  logic unused_ok;
  assign unused_ok = cmd_we;

endmodule

// File: doc/sram_arb_ctrl.md
Name: sram_arb_ctrl

Overview:
Two-port round-robin arbiter and sequencer in front of the single-port synchronous `sram` (cs/we/oe/addr, shared bidirectional data bus). It accepts read and write commands from requesters A and B, one at a time, and drives the SRAM control pins in the correct order. It owns the tristate data bus and inserts a turnaround cycle after every read. Read data is returned to the requester that issued the read, with a one-cycle valid pulse.

Parameters:
ADDR_W, 4, SRAM address width (depth = 2**ADDR_W)
DATA_W, 32, SRAM data width
RD_LAT, 1, number of cycles cs/oe are held before read data is sampled (1..4)

Ports:
clk  input  1  system clock, all state on posedge
rst  input  1  synchronous, active-high reset
a_req  input  1  requester A command valid
a_we  input  1  A: 1 = write, 0 = read
a_addr  input  ADDR_W  A command address
a_wdata  input  DATA_W  A write data
a_gnt  output  1  A command accepted this cycle (transfer = a_req & a_gnt at posedge)
a_rdata  output  DATA_W  A read data, valid while a_rvalid
a_rvalid  output  1  one-cycle pulse, A read data valid
b_req, b_we, b_addr, b_wdata, b_gnt, b_rdata, b_rvalid  same as A, for requester B
sram_cs  output  1  SRAM chip select
sram_we  output  1  SRAM write enable
sram_oe  output  1  SRAM output enable (1 = SRAM drives sram_data)
sram_addr  output  ADDR_W  SRAM address
sram_data  inout  DATA_W  shared data bus; the controller drives it only in ST_WR, otherwise hi-Z

Behaviour:
- Reset (clk edge with rst=1):
  - State goes to ST_IDLE; the priority pointer goes to A.
  - All outputs go to 0: sram_cs/we/oe, sram_addr, gnt, rvalid, rdata.
  - sram_data goes to hi-Z.
- FSM states: ST_IDLE, ST_WR, ST_RD, ST_TA.
- ST_IDLE, granting:
  - Only one req high: grant that requester. Both high: grant the requester the pointer selects.
  - x_gnt is combinational from state, pointer and reqs. It is 1 only in ST_IDLE, and only for the winner.
- ST_IDLE, on transfer (req & gnt at posedge):
  - Latch we/addr/wdata and the granted id.
  - Point the priority pointer at the other requester.
  - Next state is ST_WR if we=1, otherwise ST_RD. No req: stay in ST_IDLE with all SRAM pins idle.
- ST_WR (1 cycle):
  - sram_cs=1, sram_we=1, sram_oe=0, sram_addr=latched addr, sram_data driven with latched wdata.
  - The SRAM captures on the posedge ending this cycle. Next state is ST_IDLE.
- ST_RD (RD_LAT cycles, tracked by a down-counter):
  - sram_cs=1, sram_we=0, sram_oe=1, sram_addr=latched addr, sram_data hi-Z.
  - At the posedge ending the last ST_RD cycle, sram_data is sampled into the granted requester's rdata. Next state is ST_TA.
- ST_TA (1 cycle):
  - All SRAM pins 0 and the bus hi-Z (bus turnaround).
  - The granted requester's rvalid=1 in this cycle only. Next state is ST_IDLE.
- rdata holds its last value until the next read for the same requester. The other requester's rdata is untouched.
- Latency:
  - Write: 2 cycles from grant to the next possible grant.
  - Read: rvalid arrives RD_LAT+1 cycles after the grant cycle; the next grant is RD_LAT+2 cycles after.
- Fairness: under continuous contention, grants alternate A, B, A, B. Worst-case wait is one foreign transaction.
- Bus safety: the controller never drives sram_data while sram_oe=1, and never drives it in the cycle immediately after sram_oe=1.
- Reset mid-operation: an in-flight write is abandoned and an in-flight read is discarded, with no rvalid. The pointer returns to A.
- Address range: the full 0..2**ADDR_W-1 range is valid. There is no wrap or bounds logic; addr is passed through as latched.
- Commands are never queued. A requester holds req, we, addr and wdata stable until it is granted.

Decomposition:
- Package sram_ctrl_pkg holds:
  - state enum ST_IDLE/ST_WR/ST_RD/ST_TA
  - requester-id constants ID_A=0, ID_B=1
  - default width constants ADDR_W_DEF=4, DATA_W_DEF=32
- Sub-module rr_arb2 is a 2-way round-robin arbiter:
  - Inputs: req[1:0], enable, advance.
  - Outputs: one-hot gnt[1:0] and the registered pointer.
- The top level contains the FSM, the command latch, the RD_LAT counter, the tristate driver and the rdata/rvalid registers.

Test Plan:
1. RD_LAT=1, after reset, A write addr=3 data=0xDEADBEEF → a_gnt=1 in cycle 0; in cycle 1 cs=1, we=1, oe=0, addr=3, bus=0xDEADBEEF; in cycle 2 back in IDLE with bus hi-Z.
2. B read addr=3 after test 1 → b_gnt in cycle 0; cycle 1 cs=1 oe=1 we=0; cycle 2 b_rvalid=1, b_rdata=0xDEADBEEF, a_rvalid=0, all SRAM pins 0.
3. a_req and b_req held high together, both writes to addrs 0 and 1 → grant order A, B, A, B; each requester gets exactly one grant per 4 cycles.
4. rst=1 during the ST_RD cycle of an A read → next cycle: IDLE, all outputs 0, bus hi-Z, and no a_rvalid ever appears for that read.
5. A writes $random to addrs 0..15 back-to-back, then B reads 0..15 (RD_LAT=2) → all 16 b_rdata match the scoreboard, each rvalid 3 cycles after its grant.
6. Assertion checks throughout tests 1–5:
   - The controller never drives sram_data while sram_oe=1 or in ST_TA.
   - sram_we=1 implies sram_cs=1.
   - a_gnt and b_gnt are never both 1.
